// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 4-digit hex 7-segment scanner.
//   SEG_BLANK : segment bus value with every segment and the dp dark (active-low)
//   DIG_BLANK : digit-enable bus value with every position off (active-low)
//   seg7()    : hex nibble -> abcdefg pattern, active-high, bit6=a ... bit0=g
// -----------------------------------------------------------------------------
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] DIG_BLANK = 4'hF;

  function automatic logic [6:0] seg7(input logic [3:0] nibble);
    logic [6:0] s;
    case (nibble)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      4'hF: s = 7'b1000111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// -----------------------------------------------------------------------------
// seg7_hex_decoder
// Purely combinational: one hex nibble to the active-low abcdefgh segment bus.
// The decimal point (bit 0) is always driven off.
//   nibble_i [3:0] : hex digit to show
//   seg_n_o  [7:0] : segment drive, active-low, bit7=a ... bit1=g, bit0=dp
// -----------------------------------------------------------------------------
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] seg_n_o
);

  // dp appended as 0 before the inversion so it ends up dark (1) on the pins.
  assign seg_n_o = ~{seg7(nibble_i), 1'b0};

endmodule

// File: rtl/seg7_hex_scan4.sv
// -----------------------------------------------------------------------------
// seg7_hex_scan4
// Time-multiplexed driver for a 4-digit common-anode 7-segment display showing
// a 16-bit value as four hex digits. Each position stays lit for digit_period
// clocks; the displayed value is re-sampled only at frame boundaries so a
// frame never mixes two values.
//   clk           : system clock, rising edge
//   reset_n       : asynchronous active-low reset; outputs dark while low
//   number [15:0] : value to show; nibble i goes to position i (0 = rightmost)
//   abcdefgh [7:0]: segment drive, active-low, bit7=a ... bit0=dp
//   digit [3:0]   : digit enables, active-low, digit[i] lights position i
// -----------------------------------------------------------------------------
module seg7_hex_scan4
  import seg7_pkg::*;
#(
  parameter int clk_mhz      = 50,
  parameter int digit_period = clk_mhz * 250
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] number,
  output logic [7:0]  abcdefgh,
  output logic [3:0]  digit
);

  // digit_period is at least 2, so the counter is always at least 1 bit wide.
  localparam int              CNT_W    = $clog2(digit_period);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(digit_period - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      snap_q, snap_d;
  logic             started_q, started_d;
  logic [7:0]       seg_q, seg_d;
  logic [3:0]       dig_q, dig_d;

  logic [3:0]       cur_nibble;
  logic [7:0]       cur_seg_n;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      snap_q    <= 16'h0000;
      started_q <= 1'b0;
      seg_q     <= SEG_BLANK;
      dig_q     <= DIG_BLANK;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      started_q <= started_d;
      seg_q     <= seg_d;
      dig_q     <= dig_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    started_d = 1'b1;

    if (!started_q) begin
      // First edge after reset: take the initial snapshot and start position 0.
      snap_d = number;
      cnt_d  = '0;
      idx_d  = 2'd0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
      // Leaving position 3 ends the frame; only here may the shown value change.
      if (idx_q == 2'd3) begin
        snap_d = number;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic (registered one cycle behind the scan state)
  // ---------------------------------------------------------------------------
  assign cur_nibble = snap_q[{idx_q, 2'b00} +: 4];

  seg7_hex_decoder u_decoder (
    .nibble_i (cur_nibble),
    .seg_n_o  (cur_seg_n)
  );

  always_comb begin
    seg_d = SEG_BLANK;
    dig_d = DIG_BLANK;
    if (started_q) begin
      seg_d = cur_seg_n;
      dig_d = ~(4'b0001 << idx_q);
    end
  end

  assign abcdefgh = seg_q;
  assign digit    = dig_q;

endmodule

// File: tb/tb_seg7_hex_scan4.sv
// -----------------------------------------------------------------------------
// tb_seg7_hex_scan4
// Two scanners share clock, reset and number: one with a 4-cycle digit period
// for the directed patterns, one with default parameters for the hold length.
// The reference model derives every expected output from the number of clock
// edges since reset release: the lit position is (t / period) mod 4 and the
// shown value is the number sampled on the first edge of the current frame.
// -----------------------------------------------------------------------------
module tb_seg7_hex_scan4;

  localparam int P  = 4;
  localparam int P2 = 50 * 250;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUTs
  // ---------------------------------------------------------------------------
  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] number  = 16'h0000;
  logic [7:0]  seg_a, seg_b;
  logic [3:0]  dig_a, dig_b;

  always #5 clk = ~clk;

  seg7_hex_scan4 #(.clk_mhz(50), .digit_period(P)) dut_p4 (
    .clk      (clk),
    .reset_n  (reset_n),
    .number   (number),
    .abcdefgh (seg_a),
    .digit    (dig_a)
  );

  seg7_hex_scan4 dut_def (
    .clk      (clk),
    .reset_n  (reset_n),
    .number   (number),
    .abcdefgh (seg_b),
    .digit    (dig_b)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and compare helper
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [6:0] tbl [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                           7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                           7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  function automatic logic [3:0] model_dig(input int t, input int p);
    int pos;
    logic [3:0] d;
    pos = (t / p) % 4;
    d = 4'hF;
    d[pos] = 1'b0;
    return d;
  endfunction

  function automatic logic [7:0] model_seg(input logic [15:0] s, input int t, input int p);
    int pos;
    logic [3:0] nib;
    pos = (t / p) % 4;
    nib = 4'(s >> (4 * pos));
    return {~tbl[nib], 1'b1};
  endfunction

  int          e;           // clock edges since reset release
  logic [15:0] m_snap, m_snap2;
  logic [7:0]  exp_seg, exp_seg2;
  logic [3:0]  exp_dig, exp_dig2;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e        <= 0;
      m_snap   <= 16'h0000;
      m_snap2  <= 16'h0000;
      exp_seg  <= 8'hFF;
      exp_dig  <= 4'hF;
      exp_seg2 <= 8'hFF;
      exp_dig2 <= 4'hF;
    end else begin
      e <= e + 1;
      if (e >= 1) begin
        exp_dig  <= model_dig(e - 1, P);
        exp_seg  <= model_seg(m_snap, e - 1, P);
        exp_dig2 <= model_dig(e - 1, P2);
        exp_seg2 <= model_seg(m_snap2, e - 1, P2);
      end else begin
        exp_seg  <= 8'hFF;
        exp_dig  <= 4'hF;
        exp_seg2 <= 8'hFF;
        exp_dig2 <= 4'hF;
      end
      // The first edge of every frame (including the very first edge) samples number.
      if (e % (4 * P) == 0)  m_snap  <= number;
      if (e % (4 * P2) == 0) m_snap2 <= number;
    end
  end

  always @(negedge clk) begin
    check("model_seg_p4",  {24'h0, seg_a}, {24'h0, exp_seg});
    check("model_dig_p4",  {28'h0, dig_a}, {28'h0, exp_dig});
    check("model_seg_def", {24'h0, seg_b}, {24'h0, exp_seg2});
    check("model_dig_def", {28'h0, dig_b}, {28'h0, exp_dig2});
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic check_dark(input string name);
    check({name, "_seg_p4"},  {24'h0, seg_a}, 32'hFF);
    check({name, "_dig_p4"},  {28'h0, dig_a}, 32'hF);
    check({name, "_seg_def"}, {24'h0, seg_b}, 32'hFF);
    check({name, "_dig_def"}, {28'h0, dig_b}, 32'hF);
  endtask

  // Releases reset between edges, then pins the dark first edge and the
  // first lit digit (position 0) on the second edge.
  task automatic release_and_start(input logic [7:0] seg0);
    #2 reset_n = 1'b1;
    @(negedge clk);
    check_dark("first_edge");
    @(negedge clk);
    check("second_edge_dig", {28'h0, dig_a}, 32'hE);
    check("second_edge_seg", {24'h0, seg_a}, {24'h0, seg0});
  endtask

  task automatic apply_reset(input logic [15:0] num, input logic [7:0] seg0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    number = num;
    #1 check_dark("reset_async");
    @(negedge clk);
    check_dark("reset_held");
    release_and_start(seg0);
  endtask

  // Waits (bounded) until the 4-cycle scanner lights the given digit pattern.
  task automatic wait_digit(input string name, input logic [3:0] dig, input logic [7:0] seg);
    int k;
    k = 0;
    @(negedge clk);
    while (dig_a !== dig && k < 4 * P + 4) begin
      @(negedge clk);
      k++;
    end
    check({name, "_dig"}, {28'h0, dig_a}, {28'h0, dig});
    check({name, "_seg"}, {24'h0, seg_a}, {24'h0, seg});
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int k;

    // Power-up reset with number = 0000.
    repeat (2) @(negedge clk);
    check_dark("por");
    release_and_start(8'h03);
    wait_digit("zero_p1", 4'hD, 8'h03);
    wait_digit("zero_p2", 4'hB, 8'h03);
    wait_digit("zero_p3", 4'h7, 8'h03);
    wait_digit("zero_wrap", 4'hE, 8'h03);

    // 1234: positions 0..3 show 4, 3, 2, 1.
    apply_reset(16'h1234, 8'h99);
    wait_digit("n1234_p1", 4'hD, 8'h0D);
    wait_digit("n1234_p2", 4'hB, 8'h25);
    wait_digit("n1234_p3", 4'h7, 8'h9F);

    // ABCD: positions 0..3 show d, C, b, A.
    apply_reset(16'hABCD, 8'h85);
    wait_digit("nABCD_p1", 4'hD, 8'h63);
    wait_digit("nABCD_p2", 4'hB, 8'hC1);
    wait_digit("nABCD_p3", 4'h7, 8'h11);

    // 8F08: positions 0..3 show 8, 0, F, 8.
    apply_reset(16'h8F08, 8'h01);
    wait_digit("n8F08_p1", 4'hD, 8'h03);
    wait_digit("n8F08_p2", 4'hB, 8'h71);
    wait_digit("n8F08_p3", 4'h7, 8'h01);

    // Mid-frame change: rest of the frame keeps '1', next frame shows '2'.
    apply_reset(16'h1111, 8'h9F);
    wait_digit("mid_p1", 4'hD, 8'h9F);
    number = 16'h2222;
    wait_digit("mid_p2", 4'hB, 8'h9F);
    wait_digit("mid_p3", 4'h7, 8'h9F);
    wait_digit("mid_next_p0", 4'hE, 8'h25);

    // Reset while position 2 is lit: dark without a clock edge, clean restart.
    wait_digit("rst_mid_p2", 4'hB, 8'h25);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_dark("rst_mid_async");
    @(negedge clk);
    check_dark("rst_mid_held");
    release_and_start(8'h25);
    wait_digit("rst_mid_after_p1", 4'hD, 8'h25);

    // Default parameters: position 0 stays lit for exactly 12500 cycles.
    apply_reset(16'h8F08, 8'h01);
    k = 0;
    while (dig_b === 4'hE && k < P2 + 100) begin
      k++;
      @(negedge clk);
    end
    check("hold_default", k, P2);
    check("hold_default_next_dig", {28'h0, dig_b}, 32'hD);
    check("hold_default_next_seg", {24'h0, seg_b}, 32'h03);
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
